// File: rtl/prbs_checker.sv
// Serial PRBS-7 (x^7 + x^6 + 1) checker: self-synchronises to the incoming bit stream,
// then compares against a free-running reference and reports lock, error pulses and a saturating count.
module prbs_checker #(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [UW-1:0] MIS_LAST   = UW'(UNLOCK_COUNT - 1);

    typedef enum logic {
        ST_SEEK,
        ST_LOCKED
    } state_t;

    state_t                 state_reg, state_next;
    logic [6:0]             s_reg, s_next;
    logic [2:0]             fill_reg, fill_next;
    logic [MW-1:0]          match_reg, match_next;
    logic [UW-1:0]          mis_reg, mis_next;
    logic                   err_reg, err_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

    logic predicted;
    logic mismatch;

    assign predicted = s_reg[6] ^ s_reg[5];
    assign mismatch  = in ^ predicted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_SEEK;
            s_reg     <= '0;
            fill_reg  <= '0;
            match_reg <= '0;
            mis_reg   <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            fill_reg  <= fill_next;
            match_reg <= match_next;
            mis_reg   <= mis_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        fill_next  = fill_reg;
        match_next = match_reg;
        mis_next   = mis_reg;
        err_next   = 1'b0;
        cnt_next   = cnt_reg;

        case (state_reg)
            ST_SEEK: begin
                s_next = {s_reg[5:0], in};
                if (fill_reg != 3'd7) begin
                    fill_next = fill_reg + 3'd1;
                end else if (!mismatch && (s_reg != 7'd0)) begin
                    if (match_reg == MATCH_LAST) begin
                        state_next = ST_LOCKED;
                        match_next = '0;
                    end else begin
                        match_next = match_reg + MW'(1);
                    end
                end else begin
                    // an all-zero register predicts zeros forever, so it never counts toward lock
                    match_next = '0;
                end
            end
            ST_LOCKED: begin
                // reference runs free so a single corrupted bit yields exactly one error
                s_next = {s_reg[5:0], predicted};
                if (mismatch) begin
                    err_next = 1'b1;
                    if (cnt_reg != {CNT_WIDTH{1'b1}}) begin
                        cnt_next = cnt_reg + CNT_WIDTH'(1);
                    end
                    if (mis_reg == MIS_LAST) begin
                        state_next = ST_SEEK;
                        fill_next  = '0;
                        match_next = '0;
                        mis_next   = '0;
                    end else begin
                        mis_next = mis_reg + UW'(1);
                    end
                end else begin
                    mis_next = '0;
                end
            end
            default: begin
                state_next = ST_SEEK;
            end
        endcase

        if (clear) begin
            cnt_next = '0;
        end
    end

    assign locked    = (state_reg == ST_LOCKED);
    assign err       = err_reg;
    assign err_count = cnt_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a behavioural model pushes expected outputs per driven bit,
// popped and compared after each edge; scenario tasks add targeted latency/count checks.
module tb_prbs_checker;

    localparam int LOCK_N   = 16;
    localparam int UNLOCK_N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in = 1'b0;
    logic        clear = 1'b0;
    logic        locked_a, err_a, locked_b, err_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    prbs_checker #(.LOCK_COUNT(LOCK_N), .UNLOCK_COUNT(UNLOCK_N), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .in(in), .clear(clear),
        .locked(locked_a), .err(err_a), .err_count(cnt_a)
    );

    prbs_checker #(.LOCK_COUNT(LOCK_N), .UNLOCK_COUNT(UNLOCK_N), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .in(in), .clear(clear),
        .locked(locked_b), .err(err_b), .err_count(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    logic [6:0] gen = 7'h7F;

    // reference model state
    logic [6:0]  m_s = '0;
    int          m_fill = 0, m_match = 0, m_mis = 0;
    logic        m_lock = 1'b0, m_err = 1'b0;
    logic [15:0] m_cnt16 = '0;
    logic [3:0]  m_cnt4 = '0;

    task automatic model_step(input logic b, input logic c, input logic r);
        logic p;
        if (r) begin
            m_s = '0; m_fill = 0; m_match = 0; m_mis = 0;
            m_lock = 1'b0; m_err = 1'b0; m_cnt16 = '0; m_cnt4 = '0;
        end else begin
            p = m_s[6] ^ m_s[5];
            m_err = 1'b0;
            if (!m_lock) begin
                if (m_fill < 7) m_fill++;
                else if (b == p && m_s != 7'd0) begin
                    m_match++;
                    if (m_match == LOCK_N) begin
                        m_lock = 1'b1;
                        m_match = 0;
                    end
                end else m_match = 0;
                m_s = {m_s[5:0], b};
            end else begin
                if (b != p) begin
                    m_err = 1'b1;
                    if (m_cnt16 != 16'hFFFF) m_cnt16++;
                    if (m_cnt4 != 4'hF) m_cnt4++;
                    m_mis++;
                    if (m_mis == UNLOCK_N) begin
                        m_lock = 1'b0; m_fill = 0; m_match = 0; m_mis = 0;
                    end
                end else m_mis = 0;
                m_s = {m_s[5:0], p};
            end
            if (c) begin
                m_cnt16 = '0;
                m_cnt4 = '0;
            end
        end
    endtask

    task automatic step(input logic b, input logic c, input logic r);
        exp_t e;
        @(negedge clk);
        in = b; clear = c; rst = r;
        model_step(b, c, r);
        exp_q.push_back('{m_lock, m_err, m_cnt16, m_cnt4});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (locked_a !== e.locked) begin
            errors++;
            $display("FAIL sb_locked got %b expected %b at %0t", locked_a, e.locked, $time);
        end
        checks++;
        if (err_a !== e.err || err_b !== e.err) begin
            errors++;
            $display("FAIL sb_err got %b/%b expected %b at %0t", err_a, err_b, e.err, $time);
        end
        checks++;
        if (cnt_a !== e.cnt16) begin
            errors++;
            $display("FAIL sb_count16 got %0d expected %0d at %0t", cnt_a, e.cnt16, $time);
        end
        checks++;
        if (cnt_b !== e.cnt4 || locked_b !== e.locked) begin
            errors++;
            $display("FAIL sb_count4 got %0d/%b expected %0d/%b at %0t", cnt_b, locked_b, e.cnt4, e.locked, $time);
        end
        if (err_a === 1'b1) err_pulses++;
    endtask

    task automatic next_bit(output logic b);
        b = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
    endtask

    task automatic send(input logic flip, input logic c);
        logic b;
        next_bit(b);
        step(b ^ flip, c, 1'b0);
    endtask

    // drive n clean bits, return the 1-based bit index at which locked first read high (0 if never)
    task automatic send_until_lock(input int n, output int first);
        first = 0;
        for (int i = 1; i <= n; i++) begin
            send(1'b0, 1'b0);
            if (first == 0 && locked_a === 1'b1) first = i;
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (locked_a !== 1'b0 || err_a !== 1'b0 || cnt_a !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got locked=%b err=%b cnt=%0d expected 0/0/0", locked_a, err_a, cnt_a);
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_lock();
        int first;
        gen = 7'h7F;
        err_pulses = 0;
        send_until_lock(1000, first);
        checks++;
        if (first != 7 + LOCK_N) begin
            errors++;
            $display("FAIL lock_latency got %0d expected %0d", first, 7 + LOCK_N);
        end
        checks++;
        if (err_pulses != 0 || cnt_a !== 16'd0) begin
            errors++;
            $display("FAIL clean_errors got pulses=%0d cnt=%0d expected 0/0", err_pulses, cnt_a);
        end
        $display("test_clean_lock done first_lock=%0d", first);
    endtask

    task automatic test_single_error();
        err_pulses = 0;
        send(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) send(1'b0, 1'b0);
        checks++;
        if (err_pulses != 1 || cnt_a !== 16'd1 || locked_a !== 1'b1) begin
            errors++;
            $display("FAIL single_error got pulses=%0d cnt=%0d locked=%b expected 1/1/1", err_pulses, cnt_a, locked_a);
        end
        $display("test_single_error done");
    endtask

    task automatic test_burst_unlock();
        int first;
        send(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
        checks++;
        if (locked_a !== 1'b1) begin
            errors++;
            $display("FAIL burst_still_locked got %b expected 1", locked_a);
        end
        send(1'b1, 1'b0);
        checks++;
        if (locked_a !== 1'b0 || cnt_a !== 16'd4) begin
            errors++;
            $display("FAIL burst_unlock got locked=%b cnt=%0d expected 0/4", locked_a, cnt_a);
        end
        send_until_lock(40, first);
        checks++;
        if (first != 7 + LOCK_N || cnt_a !== 16'd4) begin
            errors++;
            $display("FAIL relock got bit=%0d cnt=%0d expected %0d/4", first, cnt_a, 7 + LOCK_N);
        end
        $display("test_burst_unlock done relock=%0d", first);
    endtask

    task automatic test_zero_ones();
        int seen_lock = 0;
        step(1'b0, 1'b0, 1'b1);
        err_pulses = 0;
        for (int i = 0; i < 400; i++) begin
            step((i >= 200), 1'b0, 1'b0);
            if (locked_a === 1'b1) seen_lock++;
        end
        checks++;
        if (seen_lock != 0 || err_pulses != 0 || cnt_a !== 16'd0) begin
            errors++;
            $display("FAIL zero_ones got lock_cycles=%0d pulses=%0d cnt=%0d expected 0/0/0", seen_lock, err_pulses, cnt_a);
        end
        $display("test_zero_ones done");
    endtask

    task automatic test_saturation();
        int first;
        step(1'b0, 1'b0, 1'b1);
        send_until_lock(7 + LOCK_N, first);
        err_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'b0);
            send(1'b0, 1'b0);
        end
        checks++;
        if (cnt_b !== 4'd15 || cnt_a !== 16'd20 || err_pulses != 20 || locked_b !== 1'b1) begin
            errors++;
            $display("FAIL saturation got cnt4=%0d cnt16=%0d pulses=%0d locked=%b expected 15/20/20/1", cnt_b, cnt_a, err_pulses, locked_b);
        end
        send(1'b1, 1'b1);
        checks++;
        if (cnt_b !== 4'd0 || cnt_a !== 16'd0 || err_b !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_error got cnt4=%0d cnt16=%0d err=%b expected 0/0/1", cnt_b, cnt_a, err_b);
        end
        send(1'b0, 1'b0);
        $display("test_saturation done");
    endtask

    task automatic test_reset_mid();
        int first;
        logic b;
        step(1'b0, 1'b0, 1'b1);
        send_until_lock(7 + LOCK_N, first);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0);
            send(1'b0, 1'b0);
        end
        checks++;
        if (cnt_a !== 16'd3 || locked_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d locked=%b expected 3/1", cnt_a, locked_a);
        end
        next_bit(b);
        step(~b, 1'b0, 1'b1);
        checks++;
        if (locked_a !== 1'b0 || err_a !== 1'b0 || cnt_a !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got locked=%b err=%b cnt=%0d expected 0/0/0", locked_a, err_a, cnt_a);
        end
        send_until_lock(40, first);
        checks++;
        if (first != 7 + LOCK_N) begin
            errors++;
            $display("FAIL reset_relock got %0d expected %0d", first, 7 + LOCK_N);
        end
        $display("test_reset_mid done relock=%0d", first);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout expected completion before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst_unlock();
        test_zero_ones();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
